// File: rtl/mux_seq_n.sv
// mux_seq_n: registered N-channel multiplexer with a round-robin sequencer.
// Manual mode registers the channel chosen by SEL. Auto mode scans every
// channel, dwelling DWELL enabled cycles on each, and pulses FIM_CICLO when
// the scan wraps back to the start.
// Optional build macro: MUX_SEQ_MASK_EN adds the MASCARA active-channel mask.
module mux_seq_n #(
    parameter int BITS     = 7,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS*BITS-1:0] D,
    input  logic [SEL_W-1:0]         SEL,
    input  logic                     modo,
    input  logic                     enable,
`ifdef MUX_SEQ_MASK_EN
    input  logic [CHANNELS-1:0]      MASCARA,
`endif
    output logic [BITS-1:0]          MUX_OUT,
    output logic [SEL_W-1:0]         CANAL,
    output logic                     FIM_CICLO
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [BITS-1:0]  ALL_ONES = {BITS{1'b1}};

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_eff_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [SEL_W-1:0] canal_r;
    logic [SEL_W-1:0] canal_next_s;
    logic [SEL_W-1:0] adv_canal_s;
    logic             adv_wrap_s;
    logic             fim_next_s;
    logic             force_ones_s;
    logic [BITS-1:0]  mux_out_r;
    logic [BITS-1:0]  mux_next_s;
    logic             fim_r;
`ifdef MUX_SEQ_MASK_EN
    logic             adv_none_s;
`endif

    // FSM state register; holds while enable is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= MANUAL;
        end else if (enable) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state decode: the mode follows modo on every enabled edge.
    always_comb begin
        next_state_s = state_r;
        if (enable) begin
            next_state_s = modo ? AUTO : MANUAL;
        end else begin
            next_state_s = state_r;
        end
    end

    // Channel the scan would advance to from CANAL, and whether that wraps.
    always_comb begin
        adv_canal_s = '0;
        adv_wrap_s  = 1'b1;
`ifdef MUX_SEQ_MASK_EN
        adv_none_s = (MASCARA == '0);
        // Descending passes leave the lowest match: first any active channel
        // (the wrap target), then the lowest active channel above CANAL.
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            adv_canal_s = MASCARA[j] ? SEL_W'(j) : adv_canal_s;
        end
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            adv_canal_s = (MASCARA[j] && (j > int'(canal_r))) ? SEL_W'(j) : adv_canal_s;
            adv_wrap_s  = (MASCARA[j] && (j > int'(canal_r))) ? 1'b0 : adv_wrap_s;
        end
`else
        // An out-of-range CANAL (left over from manual mode) wraps to 0.
        if (int'(canal_r) < CHANNELS - 1) begin
            adv_canal_s = canal_r + SEL_W'(1);
            adv_wrap_s  = 1'b0;
        end else begin
            adv_canal_s = '0;
            adv_wrap_s  = 1'b1;
        end
`endif
    end

    // Output decode: channel, dwell count, wrap pulse and selected data for
    // the coming edge. Entering auto treats the counter as freshly cleared.
    always_comb begin
        canal_next_s = canal_r;
        cnt_next_s   = '0;
        fim_next_s   = 1'b0;
        force_ones_s = 1'b0;
        cnt_eff_s    = (state_r == AUTO) ? cnt_r : '0;
        case (next_state_s)
            MANUAL: begin
                canal_next_s = SEL;
            end
            AUTO: begin
                if (cnt_eff_s == CNT_LAST) begin
                    cnt_next_s   = '0;
                    canal_next_s = adv_canal_s;
                    fim_next_s   = adv_wrap_s;
                end else begin
                    cnt_next_s   = cnt_eff_s + CNT_W'(1);
                    canal_next_s = canal_r;
                end
`ifdef MUX_SEQ_MASK_EN
                // No active channel at all: freeze on the current index.
                if (adv_none_s) begin
                    canal_next_s = canal_r;
                    fim_next_s   = 1'b0;
                    force_ones_s = 1'b1;
                end else begin
                    force_ones_s = 1'b0;
                end
`endif
            end
            default: begin
                canal_next_s = canal_r;
                cnt_next_s   = cnt_r;
            end
        endcase

        // Out-of-range (and, with the mask, manually selected masked)
        // channels read as all ones.
        mux_next_s = ALL_ONES;
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef MUX_SEQ_MASK_EN
            mux_next_s = ((canal_next_s == SEL_W'(k)) && ((next_state_s == AUTO) || MASCARA[k]))
                         ? D[k*BITS +: BITS] : mux_next_s;
`else
            mux_next_s = (canal_next_s == SEL_W'(k)) ? D[k*BITS +: BITS] : mux_next_s;
`endif
        end
        mux_next_s = force_ones_s ? ALL_ONES : mux_next_s;
    end

    // Datapath registers: CANAL and MUX_OUT always update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mux_out_r <= ALL_ONES;
            canal_r   <= '0;
            cnt_r     <= '0;
            fim_r     <= 1'b0;
        end else if (enable) begin
            mux_out_r <= mux_next_s;
            canal_r   <= canal_next_s;
            cnt_r     <= cnt_next_s;
            fim_r     <= fim_next_s;
        end else begin
            mux_out_r <= mux_out_r;
            canal_r   <= canal_r;
            cnt_r     <= cnt_r;
            fim_r     <= 1'b0;
        end
    end

    assign MUX_OUT   = mux_out_r;
    assign CANAL     = canal_r;
    assign FIM_CICLO = fim_r;

endmodule

// File: tb/tb_mux_seq_n.sv
// Directed testbench for mux_seq_n with default parameters
// (BITS=7, CHANNELS=8, SEL_W=3, DWELL=4).
module tb_mux_seq_n;

    localparam int BITS     = 7;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;
    localparam int DWELL    = 4;

    logic                     clock;
    logic                     reset;
    logic [CHANNELS*BITS-1:0] d;
    logic [SEL_W-1:0]         sel;
    logic                     modo;
    logic                     enable;
    logic [BITS-1:0]          mux_out;
    logic [SEL_W-1:0]         canal;
    logic                     fim_ciclo;
`ifdef MUX_SEQ_MASK_EN
    logic [CHANNELS-1:0]      mascara;
`endif

    int n_checks;
    int n_fail;

    mux_seq_n #(
        .BITS(BITS), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .D(d),
        .SEL(sel),
        .modo(modo),
        .enable(enable),
`ifdef MUX_SEQ_MASK_EN
        .MASCARA(mascara),
`endif
        .MUX_OUT(mux_out),
        .CANAL(canal),
        .FIM_CICLO(fim_ciclo)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic            modo;
        logic            en;
        logic [2:0]      sel;
        logic [6:0]      exp_mux;
        logic [2:0]      exp_canal;
        logic            exp_fim;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [6:0] val);
        d[k*BITS +: BITS] = val;
    endtask

    initial begin
        int exp_c;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        modo     = 1'b0;
        enable   = 1'b0;
        sel      = 3'd0;
`ifdef MUX_SEQ_MASK_EN
        mascara  = 8'hFF;
`endif
        for (int k = 0; k < CHANNELS; k++) set_ch(k, 7'(k + 10));

        // Manual-mode and mode-switch vectors, starting from reset.
        vecs[0]  = '{1'b0, 1'b1, 3'd3, 7'd13, 3'd3, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd6, 7'd16, 3'd6, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd7, 7'd17, 3'd7, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd2, 7'd17, 3'd7, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 7'd10, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd5, 7'd15, 3'd5, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 7'd15, 3'd5, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'd0, 7'd15, 3'd5, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 7'd15, 3'd5, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'd0, 7'd15, 3'd5, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'd0, 7'd16, 3'd6, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 3'd0, 7'd16, 3'd6, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'd1, 7'd11, 3'd1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'd1, 7'd11, 3'd1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'd1, 7'd11, 3'd1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 3'd1, 7'd11, 3'd1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 3'd1, 7'd12, 3'd2, 1'b0};

        // Reset state.
        step();
        check("reset_mux", mux_out, 7'h7F);
        check("reset_canal", canal, 3'd0);
        check("reset_fim", fim_ciclo, 1'b0);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            modo   = vecs[i].modo;
            enable = vecs[i].en;
            sel    = vecs[i].sel;
            step();
            check($sformatf("vec%0d_mux", i), mux_out, vecs[i].exp_mux);
            check($sformatf("vec%0d_canal", i), canal, vecs[i].exp_canal);
            check($sformatf("vec%0d_fim", i), fim_ciclo, vecs[i].exp_fim);
        end

        // Auto scan from reset: after enabled edge e, CANAL = (e/4) mod 8,
        // FIM_CICLO high only on edge 32 (the 7->0 wrap).
        reset  = 1'b1;
        modo   = 1'b1;
        enable = 1'b1;
        sel    = 3'd0;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 53; e++) begin
            step();
            exp_c = (e / 4) % 8;
            check($sformatf("scan%0d_canal", e), canal, exp_c);
            check($sformatf("scan%0d_mux", e), mux_out, exp_c + 10);
            check($sformatf("scan%0d_fim", e), fim_ciclo, (e == 32) ? 1 : 0);
        end

        // Reset between edges while on channel 5 acts at once.
        check("prereset_canal", canal, 3'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mux", mux_out, 7'h7F);
        check("async_reset_canal", canal, 3'd0);
        check("async_reset_fim", fim_ciclo, 1'b0);

        // Enable gating with the dwell counter at 2.
        step();
        reset = 1'b0;
        step();
        step();
        check("gate_start_canal", canal, 3'd0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("gate%0d_canal", i), canal, 3'd0);
            check($sformatf("gate%0d_mux", i), mux_out, 7'd10);
            check($sformatf("gate%0d_fim", i), fim_ciclo, 1'b0);
        end
        enable = 1'b1;
        step();
        check("gate_re1_canal", canal, 3'd0);
        step();
        check("gate_re2_canal", canal, 3'd1);
        check("gate_re2_mux", mux_out, 7'd11);

        // Live tracking on channel 2, then manual and back to auto.
        for (int i = 0; i < 4; i++) step();
        check("live_canal", canal, 3'd2);
        check("live_mux_before", mux_out, 7'd12);
        set_ch(2, 7'd99);
        step();
        check("live_mux_after", mux_out, 7'd99);
        check("live_canal_after", canal, 3'd2);
        modo = 1'b0;
        sel  = 3'd0;
        step();
        check("to_manual_canal", canal, 3'd0);
        check("to_manual_mux", mux_out, 7'd10);
        set_ch(2, 7'd12);
        modo = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("restart%0d_canal", i), canal, (i == 4) ? 1 : 0);
            check($sformatf("restart%0d_fim", i), fim_ciclo, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_seq_n.md
Name: mux_seq_n

Overview:
- Parametrised, registered N-channel multiplexer with a built-in channel sequencer; next generation of the team's fixed 8-input combinational mux.
- Manual mode: registered select of one channel by SEL.
- Auto mode: scans all channels round-robin, dwelling a programmable number of enabled cycles on each.
- Feeds display/debug paths that time-multiplex several data words onto one bus.

Parameters:
BITS, 7, width of each data channel and of MUX_OUT
CHANNELS, 8, number of input channels (2..256)
SEL_W, 3, width of SEL and CANAL; must satisfy 2^SEL_W >= CHANNELS
DWELL, 4, enabled cycles spent on each channel in auto mode (>=1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
D  input  CHANNELS*BITS  flattened data; channel k occupies D[k*BITS +: BITS]
SEL  input  SEL_W  channel select, used in manual mode
modo  input  1  0 = manual, 1 = auto scan
enable  input  1  1 = update state this cycle; 0 = hold everything
MUX_OUT  output  BITS  registered selected data
CANAL  output  SEL_W  index of channel currently driving MUX_OUT
FIM_CICLO  output  1  one-cycle pulse when the auto scan wraps to channel 0

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately and overrides all other inputs):
  - MUX_OUT = {BITS{1'b1}}, CANAL = 0, FIM_CICLO = 0.
  - Dwell counter = 0; FSM = MANUAL.
- FSM has two states, MANUAL and AUTO. On each enabled edge the next state is AUTO if modo=1, otherwise MANUAL.
- Every mode change clears the dwell counter.
- enable=0: MUX_OUT, CANAL, dwell counter and FSM hold; FIM_CICLO = 0.
- Coherence rule: on every enabled edge, CANAL <= canal_next and MUX_OUT <= D[canal_next] in the same edge. MUX_OUT is therefore always the current-cycle data of CANAL, with 1-cycle latency from D.
- MANUAL:
  - canal_next = SEL.
  - If SEL >= CHANNELS, MUX_OUT <= {BITS{1'b1}} and CANAL <= SEL.
  - FIM_CICLO = 0.
- AUTO:
  - Dwell counter counts 0..DWELL-1 on enabled cycles.
  - While counter < DWELL-1: canal_next = CANAL and counter increments. MUX_OUT keeps tracking live data of the same channel.
  - At counter = DWELL-1: counter <= 0 and canal_next = CANAL+1, wrapping from CHANNELS-1 to 0.
  - On the wrap edge, FIM_CICLO <= 1 for exactly one cycle.
- Manual->auto: the scan starts from the current CANAL with the counter at 0.
  - If CANAL >= CHANNELS at entry, the first advance goes to 0 and FIM_CICLO pulses.
- Auto->manual: the first enabled edge in MANUAL loads SEL.
- DWELL=1: the channel advances on every enabled edge; a full scan takes CHANNELS cycles.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MUX_SEQ_MASK_EN.
- Defined:
  - Adds input MASCARA [CHANNELS-1:0]; bit k=1 means channel k is active.
  - Auto advance goes to the next active index above CANAL, searching ascending with wrap.
  - FIM_CICLO pulses when that search wraps past CHANNELS-1.
  - If MASCARA = 0: CANAL holds, MUX_OUT = {BITS{1'b1}}, FIM_CICLO = 0.
  - Manual select of a masked channel outputs {BITS{1'b1}}.
  - MASCARA is sampled at the advance edge only.
- Undefined: no MASCARA port; all channels are active.

Test Plan:
1. Reset mid-scan (auto, CANAL=5): assert reset between edges -> outputs go to MUX_OUT=7'h7F, CANAL=0, FIM_CICLO=0 immediately, without waiting for a clock edge.
2. Manual select: D channel k = k+10, modo=0, enable=1, SEL=3 -> after 1 edge MUX_OUT=13 and CANAL=3. Then SEL=6 -> next edge MUX_OUT=16.
3. Auto scan, DWELL=4, CHANNELS=8, from reset: CANAL steps 0,1,..,7,0 with 4 enabled cycles per channel. FIM_CICLO is high exactly on the edge where CANAL goes 7->0 (edge 32 after scan start).
4. enable gating: in auto with counter=2, drop enable for 10 cycles -> CANAL, MUX_OUT and counter unchanged. Re-enable -> advance after 2 more enabled cycles.
5. Live tracking and mode switch:
   - Auto on channel 2: change D channel 2 from 12 to 99 -> MUX_OUT=99 one edge later.
   - Set modo=0 with SEL=0 -> next edge CANAL=0.
   - Set modo=1 -> dwell restarts from 0.
6. MUX_SEQ_MASK_EN:
   - MASCARA=8'b1001_0010, auto, DWELL=1 -> CANAL sequence 1,4,7,1 with FIM_CICLO on the 7->1 edge.
   - MASCARA=0 -> MUX_OUT=7'h7F and CANAL frozen.
